// File: rtl/uart_tx_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter:
//   - arb_state_e : arbiter FSM states (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE)
//   - NEWLINE     : byte that ends a locked line (8'h0A)
//   - DEF_*       : default parameter values for the arbiter
// No ports (package).
// ----------------------------------------------------------------------------
package uart_arb_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_BUSY_TIMEOUT = 4;

    localparam logic [7:0] NEWLINE = 8'h0A;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester handshake and the UART transmitter load interface.
//   req_valid [NUM_REQ]     : per-requester byte available
//   req_data  [NUM_REQ*8]   : per-requester byte, requester i at [8i+7:8i]
//   req_ready [NUM_REQ]     : one-hot accept strobe
//   tx_data_valid           : one-cycle load strobe to the UART transmitter
//   tx_data   [8]           : byte presented to the transmitter
//   transmitter_busy        : transmitter frame-in-progress flag
//   grant_id  [clog2(N)]    : requester whose byte is in flight
//   drop_err                : one-cycle pulse on busy timeout
// Modports: master = arbiter side, slave = requesters/transmitter side.
// ----------------------------------------------------------------------------
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*8-1:0]       req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       tx_data_valid;
    logic [7:0]                 tx_data;
    logic                       transmitter_busy;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic                       drop_err;

    modport master (
        input  req_valid, req_data, transmitter_busy,
        output req_ready, tx_data_valid, tx_data, grant_id, drop_err
    );

    modport slave (
        output req_valid, req_data, transmitter_busy,
        input  req_ready, tx_data_valid, tx_data, grant_id, drop_err
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Searches the request vector starting
// at ptr+1 (wrapping modulo N) and returns the first requester found.
//   req   [N]          : request vector
//   ptr   [clog2(N)]   : index of the most recent winner
//   grant [N]          : one-hot winner (all zero when no request)
//   idx   [clog2(N)]   : winner index
//   any                : at least one request present
// ----------------------------------------------------------------------------
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int N = DEF_NUM_REQ
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    int unsigned pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = ($clog2(N))'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Arbitrates NUM_REQ byte requesters onto a single UART transmitter, keeping
// at most one byte in flight. Each byte is loaded with a one-cycle
// tx_data_valid strobe; the arbiter then waits for transmitter_busy to rise
// (bounded by BUSY_TIMEOUT cycles, else drop_err) and fall before accepting
// the next byte.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : uart_tx_arbiter_if.master (requesters + transmitter signals)
// Parameters: NUM_REQ (2..8), BUSY_TIMEOUT (cycles to wait for busy).
// Optional feature: define UART_ARB_LINE_LOCK_EN to keep serving the same
// requester until it sends a newline (8'h0A) or that newline times out.
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    // Reset pointer so that requester 0 is the first to win.
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [7:0]         pick_byte;
    logic [NUM_REQ-1:0] req_ready_c;
    logic               drop_c;

`ifdef UART_ARB_LINE_LOCK_EN
    logic lock_q, lock_d;

    // While locked, only the current owner (grant_id) may be considered.
    always_comb begin
        eligible = bus.req_valid;
        if (lock_q) begin
            eligible = bus.req_valid & (NUM_REQ'(1) << grant_id_q);
        end
    end
`else
    always_comb begin
        eligible = bus.req_valid;
    end
`endif

    rr_picker #(
        .N (NUM_REQ)
    ) u_picker (
        .req   (eligible),
        .ptr   (last_grant_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign pick_byte = bus.req_data[{pick_idx, 3'b000} +: 8];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = 1'b0;
        cnt_d        = cnt_q;
        req_ready_c  = '0;
        drop_c       = 1'b0;
`ifdef UART_ARB_LINE_LOCK_EN
        lock_d       = lock_q;
`endif

        case (state_q)
            IDLE: begin
                // No byte is accepted while rst is high.
                if (!rst && !bus.transmitter_busy && pick_any) begin
                    req_ready_c = pick_grant;
                    grant_id_d  = pick_idx;
                    tx_data_d   = pick_byte;
                    tx_valid_d  = 1'b1;
                    state_d     = ISSUE;
`ifdef UART_ARB_LINE_LOCK_EN
                    // A newline ends the line, so it never (re)arms the lock.
                    lock_d      = (pick_byte != NEWLINE);
`endif
                end
            end

            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                if (bus.transmitter_busy) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Last allowed low cycle: give up on this byte.
                    drop_c       = ~rst;
                    cnt_d        = '0;
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WAIT_DONE: begin
                if (!bus.transmitter_busy) begin
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_RST;
            grant_id_q   <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef UART_ARB_LINE_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    assign bus.req_ready     = req_ready_c;
    assign bus.tx_data_valid = tx_valid_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.grant_id      = grant_id_q;
    assign bus.drop_err      = drop_c;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level reference model. Honours UART_ARB_LINE_LOCK_EN.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N  = 4;
    localparam int BT = 4;

    localparam int U_NORMAL = 0;
    localparam int U_MUTE   = 1;
    localparam int U_FORCE  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Requester byte sources (ring buffers).
    logic [7:0] src_mem [N][64];
    int head [N];
    int tail [N];

    // Observations captured at each falling edge.
    logic [N-1:0] hs_mask = '0;
    logic         txv_seen = 1'b0;
    logic [7:0]   issued[$];
    int           issued_cyc[$];
    int           drop_cyc[$];

    // Transmitter model controls.
    int u_mode = U_NORMAL;
    int u_wait = -1;
    int u_len  = 0;
    int u_dmax = 2;
    int u_lmin = 1;
    int u_lmax = 5;
    bit rnd    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        src_mem[i][tail[i] % 64] = b;
        tail[i]++;
    endtask

    // Advance one clock and drive all inputs for the new cycle.
    task automatic step();
        logic [N-1:0]   rv;
        logic [N*8-1:0] rd;
        logic           busy;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_mask[i] && head[i] != tail[i]) head[i]++;
            if (rnd && (tail[i] - head[i]) < 3 && $urandom_range(0, 3) == 0)
                push(i, ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom));
        end
        busy = 1'b0;
        if (u_mode == U_FORCE) begin
            busy = 1'b1;
        end else begin
            if (txv_seen && u_mode == U_NORMAL) begin
                if (rnd && $urandom_range(0, 5) == 0) begin
                    u_wait = -1;
                end else begin
                    u_wait = $urandom_range(0, u_dmax);
                    u_len  = $urandom_range(u_lmin, u_lmax);
                end
            end
            if (u_wait > 0) begin
                u_wait--;
            end else if (u_wait == 0) begin
                busy = 1'b1;
                u_len--;
                if (u_len <= 0) u_wait = -1;
            end else if (rnd && $urandom_range(0, 15) == 0) begin
                busy = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            rv[i] = (head[i] != tail[i]) && (!rnd || $urandom_range(0, 3) != 0);
            rd[i*8 +: 8] = (head[i] != tail[i]) ? src_mem[i][head[i] % 64] : 8'($urandom);
        end
        bus.req_valid        = rv;
        bus.req_data         = rd;
        bus.transmitter_busy = busy;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        u_wait = -1;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        step();
        rst = 1'b0;
    endtask

    task automatic wait_issued(input int k, input int budget, input string nm);
        int t;
        t = 0;
        while (issued.size() < k && t < budget) begin
            step();
            t++;
        end
        checks++;
        if (issued.size() < k) begin
            errors++;
            $display("FAIL %s: timeout, issued %0d bytes required %0d", nm, issued.size(), k);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and per-cycle compare (falling edge).
    // The model tracks one outstanding byte by its age in cycles since
    // acceptance: age 1 is the load strobe, ages 2..BT+1 are the window in
    // which busy must rise, after which the byte completes when busy falls.
    // ------------------------------------------------------------------
    initial begin : model
        bit         m_known;
        bit         m_free;
        bit         m_got;
        int         m_since;
        int         m_last;
        int         m_gid;
        int         m_lock;
        logic [7:0] m_txd;
        logic [N-1:0] rv, elig, exp_ready;
        logic       b, r, exp_txv, exp_drop;
        int         pick, j;
        logic [7:0] pbyte;
        m_known = 1'b0;
        m_free = 1'b1; m_got = 1'b0; m_since = 0; m_last = N - 1;
        m_gid = 0; m_lock = -1; m_txd = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            hs_mask  = bus.req_valid & bus.req_ready;
            txv_seen = bus.tx_data_valid;
            if (bus.tx_data_valid === 1'b1) begin
                issued.push_back(bus.tx_data);
                issued_cyc.push_back(cyc);
            end
            if (bus.drop_err === 1'b1) drop_cyc.push_back(cyc);

            r  = rst;
            b  = bus.transmitter_busy;
            rv = bus.req_valid;
            if (m_known) begin
                exp_ready = '0;
                pick      = -1;
                pbyte     = 8'h00;
                if (!r && m_free && !b) begin
                    elig = rv;
                    if (m_lock >= 0) elig = rv & (N'(1) << m_lock);
                    for (int k = 1; k <= N; k++) begin
                        j = (m_last + k) % N;
                        if (pick < 0 && elig[j]) pick = j;
                    end
                    if (pick >= 0) begin
                        exp_ready[pick] = 1'b1;
                        pbyte = bus.req_data[pick*8 +: 8];
                    end
                end
                exp_txv  = !m_free && (m_since == 1);
                exp_drop = !r && !m_free && !m_got && (m_since == BT + 1) && !b;

                chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
                chk("tx_data_valid", 32'(bus.tx_data_valid), 32'(exp_txv));
                chk("tx_data", 32'(bus.tx_data), 32'(m_txd));
                chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
                chk("drop_err", 32'(bus.drop_err), 32'(exp_drop));

                if (!r) begin
                    if (m_free) begin
                        if (pick >= 0) begin
                            m_free  = 1'b0;
                            m_got   = 1'b0;
                            m_since = 1;
                            m_gid   = pick;
                            m_txd   = pbyte;
`ifdef UART_ARB_LINE_LOCK_EN
                            m_lock  = (pbyte == 8'h0A) ? -1 : pick;
`endif
                        end
                    end else begin
                        if (exp_drop || (m_got && !b)) begin
                            m_free = 1'b1;
                            m_last = m_gid;
                        end else if (!m_got && m_since >= 2 && b) begin
                            m_got = 1'b1;
                        end
                        m_since++;
                    end
                end
            end
            if (r) begin
                m_known = 1'b1;
                m_free = 1'b1; m_got = 1'b0; m_since = 0; m_last = N - 1;
                m_gid = 0; m_lock = -1; m_txd = 8'h00;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus and directed literal checks.
    // ------------------------------------------------------------------
    initial begin : stim
        logic [7:0] exp_seq [5];
        logic [7:0] exp_line [4];
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        bus.req_valid        = '0;
        bus.req_data         = '0;
        bus.transmitter_busy = 1'b0;

        // Reset values.
        do_reset();
        @(negedge clk);
        chk("rst_tx_valid", 32'(bus.tx_data_valid), 32'h0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'h0);
        chk("rst_drop_err", 32'(bus.drop_err), 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);

        // Single byte from requester 0.
        push(0, 8'h55);
        step();
        @(negedge clk);
        chk("single_ready", 32'(bus.req_ready), 32'h1);
        step();
        @(negedge clk);
        chk("single_txv", 32'(bus.tx_data_valid), 32'h1);
        chk("single_txd", 32'(bus.tx_data), 32'h55);
        chk("single_gid", 32'(bus.grant_id), 32'h0);
        repeat (12) step();

        // All requesters valid: round-robin order.
        do_reset();
        issued.delete();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++) push(i, 8'(8'h10 + i));
        wait_issued(5, 200, "rr_wait");
`ifdef UART_ARB_LINE_LOCK_EN
        exp_seq = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
`else
        exp_seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
`endif
        for (int i = 0; i < 5; i++)
            chk("rr_order", (i < issued.size()) ? 32'(issued[i]) : 32'hFFFF, 32'(exp_seq[i]));
        repeat (10) step();

        // Busy held high while requester 2 becomes valid.
        do_reset();
        u_mode = U_FORCE;
        push(2, 8'h42);
        repeat (5) begin
            step();
            @(negedge clk);
            chk("busy_hold_ready", 32'(bus.req_ready), 32'h0);
        end
        u_mode = U_NORMAL;
        step();
        @(negedge clk);
        chk("busy_release_ready", 32'(bus.req_ready), 32'h4);
        repeat (12) step();

        // Transmitter never raises busy: timeout and next requester.
        do_reset();
        u_mode = U_MUTE;
        issued.delete();
        issued_cyc.delete();
        drop_cyc.delete();
        push(0, 8'h0A);
        push(1, 8'h21);
        wait_issued(2, 100, "timeout_wait");
        chk("drop_latency", (drop_cyc.size() > 0 && issued_cyc.size() > 0) ?
            32'(drop_cyc[0] - issued_cyc[0]) : 32'hFFFF, 32'd4);
        chk("timeout_next", (issued.size() > 1) ? 32'(issued[1]) : 32'hFFFF, 32'h21);
        repeat (10) step();
        u_mode = U_NORMAL;

        // Line lock: requester 1 sends "ok\n", requester 0 joins later.
        do_reset();
        issued.delete();
        push(1, 8'h6F);
        push(1, 8'h6B);
        push(1, 8'h0A);
        wait_issued(1, 50, "line_first");
        push(0, 8'h30);
        wait_issued(4, 200, "line_wait");
`ifdef UART_ARB_LINE_LOCK_EN
        exp_line = '{8'h6F, 8'h6B, 8'h0A, 8'h30};
`else
        exp_line = '{8'h6F, 8'h30, 8'h6B, 8'h0A};
`endif
        for (int i = 0; i < 4; i++)
            chk("line_order", (i < issued.size()) ? 32'(issued[i]) : 32'hFFFF, 32'(exp_line[i]));
        repeat (10) step();

        // Reset during WAIT_DONE.
        do_reset();
        u_dmax = 0;
        u_lmin = 6;
        u_lmax = 6;
        issued.delete();
        push(2, 8'hA2);
        wait_issued(1, 50, "wd_first");
        push(0, 8'hB0);
        push(3, 8'hB3);
        step();
        rst = 1'b1;
        u_wait = -1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("wd_rst_txv", 32'(bus.tx_data_valid), 32'h0);
        chk("wd_rst_txd", 32'(bus.tx_data), 32'h0);
        chk("wd_rst_gid", 32'(bus.grant_id), 32'h0);
        chk("wd_rst_drop", 32'(bus.drop_err), 32'h0);
        chk("wd_rst_ready", 32'(bus.req_ready), 32'h1);
        issued.delete();
        wait_issued(1, 50, "wd_next");
        chk("wd_first_grant", (issued.size() > 0) ? 32'(issued[0]) : 32'hFFFF, 32'hB0);
        u_dmax = 2;
        u_lmin = 1;
        u_lmax = 5;
        repeat (10) step();

        // Randomized traffic with occasional resets.
        do_reset();
        rnd = 1'b1;
        repeat (3000) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end
        rnd = 1'b0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
